// File: rtl/rf_pkg.sv
// Shared types for the register-file init/bypass front end.
package rf_pkg;

  localparam int NUM_RD_PORTS = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_bypass_lane.sv
// One read port: registers a same-edge write hit and selects forwarded or RAM data.
module rf_bypass_lane #(
  parameter int WIDTH  = 3,
  parameter int AWIDTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] rd_addr,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              run,
  input  logic [WIDTH-1:0]  ram_q,
  output logic [WIDTH-1:0]  rd_data
);

  logic             hit_q;
  logic             rd_valid_q;
  logic [WIDTH-1:0] wdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      wdata_q    <= '0;
    end else begin
      hit_q      <= run & wr_en & (wr_addr == rd_addr);
      rd_valid_q <= run;
      wdata_q    <= wr_data;
    end
  end

  // RAM returns old data on a same-edge collision, so the captured write wins.
  assign rd_data = rd_valid_q ? (hit_q ? wdata_q : ram_q) : '0;

endmodule

// File: rtl/rf_init_bypass.sv
// MLAB register-file front end: zero-fills after reset, then passes CPU
// accesses through with read-during-write forwarding on both read ports.
module rf_init_bypass
  import rf_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int AWIDTH = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [AWIDTH-1:0] RD_A_ADDR,
  input  logic [AWIDTH-1:0] RD_B_ADDR,
  input  logic [AWIDTH-1:0] WR_ADDR,
  input  logic [WIDTH-1:0]  WR_DATA,
  input  logic              WR_EN,
  output logic [WIDTH-1:0]  RD_A_DATA,
  output logic [WIDTH-1:0]  RD_B_DATA,
  output logic              READY,
  output logic [AWIDTH-1:0] RAM_A_ADDR,
  output logic [AWIDTH-1:0] RAM_B_ADDR,
  output logic [AWIDTH-1:0] RAM_C_ADDR,
  output logic [WIDTH-1:0]  RAM_C_DATA,
  output logic              RAM_C_WE,
  input  logic [WIDTH-1:0]  RAM_A_Q,
  input  logic [WIDTH-1:0]  RAM_B_Q
);

  localparam int DEPTH = 1 << AWIDTH;

  rf_state_e         state, state_nxt;
  logic [AWIDTH-1:0] cnt, cnt_nxt;
  logic              run;
  logic              we_raw;

  logic [NUM_RD_PORTS-1:0][AWIDTH-1:0] rd_addr_v;
  logic [NUM_RD_PORTS-1:0][WIDTH-1:0]  ram_q_v;
  logic [NUM_RD_PORTS-1:0][WIDTH-1:0]  rd_data_v;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    RAM_C_ADDR = WR_ADDR;
    RAM_C_DATA = WR_DATA;
    we_raw     = WR_EN;
    case (state)
      INIT: begin
        // CPU writes during the fill are dropped, not queued.
        RAM_C_ADDR = cnt;
        RAM_C_DATA = '0;
        we_raw     = 1'b1;
        cnt_nxt    = cnt + AWIDTH'(1);
        if (cnt == AWIDTH'(DEPTH - 1)) state_nxt = RUN;
      end
      RUN: ;
      default: state_nxt = INIT;
    endcase
  end

  assign run        = (state == RUN);
  assign READY      = run;
  assign RAM_C_WE   = we_raw & RST_N;
  assign RAM_A_ADDR = RD_A_ADDR;
  assign RAM_B_ADDR = RD_B_ADDR;

  assign rd_addr_v = {RD_B_ADDR, RD_A_ADDR};
  assign ram_q_v   = {RAM_B_Q, RAM_A_Q};
  assign RD_A_DATA = rd_data_v[0];
  assign RD_B_DATA = rd_data_v[1];

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_lane
    rf_bypass_lane #(
      .WIDTH (WIDTH),
      .AWIDTH(AWIDTH)
    ) u_lane (
      .clk    (CLK),
      .rst_n  (RST_N),
      .rd_addr(rd_addr_v[p]),
      .wr_addr(WR_ADDR),
      .wr_en  (WR_EN),
      .wr_data(WR_DATA),
      .run    (run),
      .ram_q  (ram_q_v[p]),
      .rd_data(rd_data_v[p])
    );
  end

endmodule
